// File: rtl/ee354_snake_pkg.sv
// Shared encodings for the snake game: directions, move-controller states,
// playfield defaults and {x,y} cell packing.
package ee354_snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_WAIT  = 3'd2,
    S_NEXT  = 3'd3,
    S_SCAN  = 3'd4,
    S_WRITE = 3'd5,
    S_DEAD  = 3'd6
  } state_t;

  localparam int GRID_W_DEF   = 15;
  localparam int GRID_H_DEF   = 15;
  localparam int MAX_LEN_DEF  = 225;
  localparam int INIT_LEN_DEF = 3;

  // Row the fresh snake is laid out on.
  localparam logic [3:0] INIT_ROW = 4'd7;

  function automatic logic [7:0] pack_xy(input logic [3:0] x, input logic [3:0] y);
    return {x, y};
  endfunction

  // UP<->DOWN and LEFT<->RIGHT differ only in bit 0.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'd1);
  endfunction

endpackage

// File: rtl/snake_body_ram.sv
// 256x8 single-port body RAM, synchronous read with one cycle of latency.
// Instantiated beside snake_move_ctrl at the game top level.
module snake_body_ram (
  input  logic       Clk,
  input  logic [7:0] Addr,
  input  logic       WE,
  input  logic [7:0] WData,
  output logic [7:0] RData
);

  logic [7:0] mem [256];

  always_ff @(posedge Clk) begin
    if (WE) mem[Addr] <= WData;
    RData <= mem[Addr];
  end

endmodule

// File: rtl/snake_move_ctrl.sv
// One snake move per game tick: direction latch, wall check, body scan
// through the external body RAM, then head commit. Define WRAP_WALLS_EN
// to make the playfield edges wrap instead of acting as walls.
module snake_move_ctrl
  import ee354_snake_pkg::*;
#(
  parameter int GRID_W   = GRID_W_DEF,
  parameter int GRID_H   = GRID_H_DEF,
  parameter int MAX_LEN  = MAX_LEN_DEF,
  parameter int INIT_LEN = INIT_LEN_DEF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Init,
  input  logic       Run,
  input  logic       Tick,
  input  logic       BtnU,
  input  logic       BtnD,
  input  logic       BtnL,
  input  logic       BtnR,
  input  logic [3:0] Food_X,
  input  logic [3:0] Food_Y,
  output logic [7:0] Mem_Addr,
  output logic       Mem_WE,
  output logic [7:0] Mem_WData,
  input  logic [7:0] Mem_RData,
  output logic       Collision,
  output logic [7:0] Length,
  output logic       Food_Eaten,
  output logic [3:0] Head_X,
  output logic [3:0] Head_Y,
  output logic       Busy,
  output logic [2:0] State_Dbg
);

  localparam logic [3:0] X_MAX   = 4'(GRID_W - 1);
  localparam logic [3:0] Y_MAX   = 4'(GRID_H - 1);
  localparam logic [7:0] LEN_MAX = 8'(MAX_LEN);

  state_t     state;
  dir_t       dir, move_dir;
  logic [7:0] head_ptr;
  logic [7:0] new_xy;
  logic       grow;
  logic [7:0] scan_n, scan_j;
  logic [3:0] init_cnt;

  dir_t       req_dir;
  logic       req_valid;
  logic       at_edge, wall_hit, grow_c;
  logic [3:0] nx, ny;
  logic [7:0] scan_n_c;

  assign State_Dbg = state;
  assign Busy      = !(state == S_IDLE || state == S_WAIT || state == S_DEAD);

  always_comb begin
    req_valid = 1'b1;
    req_dir   = RIGHT;
    if (BtnU)      req_dir = UP;
    else if (BtnD) req_dir = DOWN;
    else if (BtnL) req_dir = LEFT;
    else if (BtnR) req_dir = RIGHT;
    else           req_valid = 1'b0;
  end

  // Edge detection happens before any 4-bit arithmetic so 0-1 never aliases.
  always_comb begin
    nx      = Head_X;
    ny      = Head_Y;
    at_edge = 1'b0;
    case (dir)
      UP:      begin at_edge = (Head_Y == 4'd0);  ny = at_edge ? Y_MAX : Head_Y - 4'd1; end
      DOWN:    begin at_edge = (Head_Y == Y_MAX); ny = at_edge ? 4'd0  : Head_Y + 4'd1; end
      LEFT:    begin at_edge = (Head_X == 4'd0);  nx = at_edge ? X_MAX : Head_X - 4'd1; end
      default: begin at_edge = (Head_X == X_MAX); nx = at_edge ? 4'd0  : Head_X + 4'd1; end
    endcase
`ifdef WRAP_WALLS_EN
    wall_hit = 1'b0;
`else
    wall_hit = at_edge;
`endif
    grow_c   = (pack_xy(nx, ny) == pack_xy(Food_X, Food_Y)) && (Length < LEN_MAX);
    scan_n_c = grow_c ? Length : Length - 8'd1;
  end

  // Tick is a one-cycle strobe taken only in S_WAIT with Run high; no backpressure.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= S_IDLE;
      Collision  <= 1'b0;
      Length     <= 8'd0;
      Food_Eaten <= 1'b0;
      Mem_WE     <= 1'b0;
      Mem_Addr   <= 8'd0;
      Mem_WData  <= 8'd0;
      Head_X     <= 4'd0;
      Head_Y     <= 4'd0;
      head_ptr   <= 8'd0;
      dir        <= RIGHT;
      move_dir   <= RIGHT;
      new_xy     <= 8'd0;
      grow       <= 1'b0;
      scan_n     <= 8'd0;
      scan_j     <= 8'd0;
      init_cnt   <= 4'd0;
    end else begin
      Mem_WE     <= 1'b0;
      Food_Eaten <= 1'b0;
      if (Init) begin
        state     <= S_INIT;
        Collision <= 1'b0;
        head_ptr  <= 8'd0;
        dir       <= RIGHT;
        move_dir  <= RIGHT;
        init_cnt  <= 4'd0;
      end else begin
        if (req_valid && req_dir != opposite(move_dir)) dir <= req_dir;
        case (state)
          S_INIT: begin
            if (init_cnt < 4'(INIT_LEN)) begin
              Mem_WE    <= 1'b1;
              Mem_Addr  <= {4'd0, init_cnt};
              Mem_WData <= pack_xy(init_cnt, INIT_ROW);
              init_cnt  <= init_cnt + 4'd1;
            end else begin
              Head_X   <= 4'(INIT_LEN - 1);
              Head_Y   <= INIT_ROW;
              head_ptr <= 8'(INIT_LEN - 1);
              Length   <= 8'(INIT_LEN);
              state    <= S_WAIT;
            end
          end
          S_WAIT: if (Tick && Run) state <= S_NEXT;
          S_NEXT: begin
            move_dir <= dir;
            if (wall_hit) begin
              Collision <= 1'b1;
              state     <= S_DEAD;
            end else begin
              new_xy   <= pack_xy(nx, ny);
              grow     <= grow_c;
              scan_n   <= scan_n_c;
              scan_j   <= 8'd0;
              Mem_Addr <= head_ptr;
              state    <= S_SCAN;
            end
          end
          // Cycle j issues segment j and compares the data of segment j-1.
          S_SCAN: begin
            if (scan_j != 8'd0 && Mem_RData == new_xy) begin
              Collision <= 1'b1;
              state     <= S_DEAD;
            end else if (scan_j == scan_n) begin
              head_ptr  <= head_ptr + 8'd1;
              Mem_WE    <= 1'b1;
              Mem_Addr  <= head_ptr + 8'd1;
              Mem_WData <= new_xy;
              Head_X    <= new_xy[7:4];
              Head_Y    <= new_xy[3:0];
              if (grow) begin
                Length     <= Length + 8'd1;
                Food_Eaten <= 1'b1;
              end
              state <= S_WRITE;
            end else begin
              scan_j   <= scan_j + 8'd1;
              Mem_Addr <= head_ptr - scan_j - 8'd1;
            end
          end
          S_WRITE: state <= S_WAIT;
          S_DEAD:  Collision <= 1'b1;
          S_IDLE:  ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
